instruction_fetch_unit: RTL

//  Consumer side of the program counter: fetches the word at pc from instruction memory over a req/ack handshake.

---
 rtl/ifu_pkg.sv | 45 ++++
 rtl/instr_field_decode.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, 32-bit instruction
// field positions and the NOP word loaded into the instruction register on reset.
package ifu_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2,
    StError = 2'd3
  } ifu_state_e;

  localparam int unsigned INSTR_W = 32;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned SHA_HI = 10;
  localparam int unsigned SHA_LO = 6;
  localparam int unsigned FN_HI  = 5;
  localparam int unsigned FN_LO  = 0;
  localparam int unsigned JMP_HI = 25;
  localparam int unsigned JMP_LO = 0;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  localparam int unsigned OPC_W = OPC_HI - OPC_LO + 1;
  localparam int unsigned REG_W = RS_HI - RS_LO + 1;
  localparam int unsigned SHA_W = SHA_HI - SHA_LO + 1;
  localparam int unsigned FN_W  = FN_HI - FN_LO + 1;
  localparam int unsigned JMP_W = JMP_HI - JMP_LO + 1;
  localparam int unsigned IMM_W = IMM_HI - IMM_LO + 1;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  // Width of a counter that must be able to hold the value max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Pure combinational slicer of a 32-bit instruction word into its fields.
// Shared with the control unit so both see identical field boundaries.
module instr_field_decode
  import ifu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   rd,
  output logic [SHA_W-1:0]   shamt,
  output logic [FN_W-1:0]    funct,
  output logic [JMP_W-1:0]   jump_address,
  output logic [IMM_W-1:0]   branch_offset
);

  assign opcode        = instr[OPC_HI:OPC_LO];
  assign rs            = instr[RS_HI:RS_LO];
  assign rt            = instr[RT_HI:RT_LO];
  assign rd            = instr[RD_HI:RD_LO];
  assign shamt         = instr[SHA_HI:SHA_LO];
  assign funct         = instr[FN_HI:FN_LO];
  assign jump_address  = instr[JMP_HI:JMP_LO];
  assign branch_offset = instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches the word at pc over a req/ack memory handshake, holds it in IR and offers it
// downstream over valid/ready; pc_advance strobes once per consumed instruction.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [25:0]       jump_address,
  output logic [15:0]       branch_offset,
  output logic              pc_advance,
  output logic              fetch_error
);

  localparam int unsigned CntW      = cnt_width(TIMEOUT);
  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  ifu_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              fetch_error_q, fetch_error_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              discard_q, discard_d;
  logic [CntW-1:0]   count_inc;
  logic              advance;

  assign count_inc = count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      ir_q          <= DATA_W'(NOP);
      ir_valid_q    <= 1'b0;
      fetch_error_q <= 1'b0;
      count_q       <= '0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      fetch_error_q <= fetch_error_d;
      count_q       <= count_d;
      discard_q     <= discard_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    fetch_error_d = fetch_error_q;
    count_d       = count_q;
    discard_d     = discard_q;
    advance       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fetch_en && !flush) begin
          state_d    = StFetch;
          mem_req_d  = 1'b1;
          mem_addr_d = pc;
          count_d    = '0;
          discard_d  = 1'b0;
        end
      end

      StFetch: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          count_d   = '0;
          discard_d = 1'b0;
          // A flush anywhere in this fetch, including the ack cycle, drops the word.
          if (discard_q || flush) begin
            state_d = StIdle;
          end else begin
            ir_d       = mem_rdata;
            ir_valid_d = 1'b1;
            state_d    = StHold;
          end
        end else begin
          if (flush) begin
            discard_d = 1'b1;
          end
          if (TimeoutEn) begin
            count_d = count_inc;
            if (count_inc == TimeoutCnt) begin
              state_d       = StError;
              mem_req_d     = 1'b0;
              fetch_error_d = 1'b1;
              count_d       = '0;
              discard_d     = 1'b0;
            end
          end
        end
      end

      StHold: begin
        if (flush) begin
          ir_valid_d = 1'b0;
          state_d    = StIdle;
        end else if (ir_ready) begin
          advance    = 1'b1;
          ir_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end

      StError: begin
        if (flush) begin
          state_d       = StIdle;
          fetch_error_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // pc_advance must coincide with the handshake cycle so the PC moves on that same edge
  // and IDLE samples the new pc; hence it is decoded, not registered.
  assign pc_advance  = advance && !rst;

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign ir_valid    = ir_valid_q;
  assign instr       = ir_q;
  assign fetch_error = fetch_error_q;

  instr_field_decode u_decode (
    .instr        (ir_q[INSTR_W-1:0]),
    .opcode       (opcode),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .shamt        (shamt),
    .funct        (funct),
    .jump_address (jump_address),
    .branch_offset(branch_offset)
  );

endmodule
